// File: rtl/cfg_frame_loader_if.sv
// cfg_frame_loader_if: bitstream-in / latch-row-out bundle for the configuration frame loader
//   cfg_start      start or restart a load sequence (1-cycle pulse)
//   cfg_in_valid   cfg_in_bit carries a bitstream bit this cycle
//   cfg_in_bit     serial bitstream, MSB-first
//   cfg_in_ready   loader accepts a bit this cycle
//   frame_data     d inputs of the latch rows
//   frame_strobe   one-hot latch enable, one bit per row
//   busy/done/err  sequence status
interface cfg_frame_loader_if #(
  parameter int FRAME_W  = 32,
  parameter int N_FRAMES = 16
) ();
  logic                cfg_start;
  logic                cfg_in_valid;
  logic                cfg_in_bit;
  logic                cfg_in_ready;
  logic [FRAME_W-1:0]  frame_data;
  logic [N_FRAMES-1:0] frame_strobe;
  logic                busy;
  logic                done;
  logic                err;
  modport master (
    output cfg_start, cfg_in_valid, cfg_in_bit,
    input  cfg_in_ready, frame_data, frame_strobe, busy, done, err
  );
  modport slave (
    input  cfg_start, cfg_in_valid, cfg_in_bit,
    output cfg_in_ready, frame_data, frame_strobe, busy, done, err
  );
endinterface

// File: rtl/cfg_frame_loader.sv
// cfg_frame_loader: deserialises {address, frame} records and strobes one latch row per frame
//   clk  rising-edge clock
//   rn   asynchronous active-low reset
//   bus  cfg_frame_loader_if.slave (bitstream in, latch row data/strobe and status out)
module cfg_frame_loader #(
  parameter int FRAME_W    = 32,
  parameter int N_FRAMES   = 16,
  parameter int STROBE_CYC = 2,
  parameter int ADDR_W     = $clog2(N_FRAMES + 1)
) (
  input logic               clk,
  input logic               rn,
  cfg_frame_loader_if.slave bus
);
  localparam int M1 = FRAME_W > ADDR_W ? FRAME_W : ADDR_W;
  localparam int MX = M1 > STROBE_CYC ? M1 : STROBE_CYC;
  localparam int CW = $clog2(MX + 1);
  // the all-ones address is the end marker, so every row must sit below it
  if ((2 ** ADDR_W) - 1 < N_FRAMES || STROBE_CYC < 1 || STROBE_CYC > 15) begin : g_bad_cfg
    $error("cfg_frame_loader: ADDR_W too small for N_FRAMES or STROBE_CYC outside 1..15");
  end
  typedef enum logic [2:0] {IDLE, ADDR, DATA, STROBE, HOLD, DONE, ERR} st_t;
  st_t                 st_q, st_d;
  logic [ADDR_W-1:0]   addr_q, addr_d, addr_sh;
  logic [FRAME_W-1:0]  data_q, data_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [N_FRAMES-1:0] strobe_q, strobe_d;
  logic                ready_q, busy_q, done_q, err_q, acc;
  always_comb begin
    st_d    = st_q;
    addr_d  = addr_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    acc     = bus.cfg_in_valid && ready_q;
    addr_sh = ADDR_W'({addr_q, bus.cfg_in_bit});
    // start wins over any count ending in the same cycle
    if (bus.cfg_start) begin
      st_d   = ADDR;
      addr_d = '0;
      data_d = '0;
      cnt_d  = '0;
    end else begin
      case (st_q)
        ADDR: if (acc) begin
          addr_d = addr_sh;
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == CW'(ADDR_W - 1)) begin
            cnt_d = '0;
            st_d  = addr_sh < ADDR_W'(N_FRAMES) ? DATA : (&addr_sh ? DONE : ERR);
          end
        end
        DATA: if (acc) begin
          data_d = FRAME_W'({data_q, bus.cfg_in_bit});
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == CW'(FRAME_W - 1)) begin
            cnt_d = '0;
            st_d  = STROBE;
          end
        end
        STROBE: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(STROBE_CYC - 1)) begin
            cnt_d = '0;
            st_d  = HOLD;
          end
        end
        HOLD:    st_d = ADDR;
        default: st_d = st_q;
      endcase
    end
    // outputs are registered from the next state so they line up with st_q
    strobe_d = st_d == STROBE ? N_FRAMES'(1) << addr_d : '0;
  end
  always_ff @(posedge clk or negedge rn) begin
    if (!rn) begin
      st_q     <= IDLE;
      addr_q   <= '0;
      data_q   <= '0;
      cnt_q    <= '0;
      strobe_q <= '0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      st_q     <= st_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      cnt_q    <= cnt_d;
      strobe_q <= strobe_d;
      ready_q  <= st_d inside {ADDR, DATA};
      busy_q   <= st_d inside {ADDR, DATA, STROBE, HOLD};
      done_q   <= st_d == DONE;
      err_q    <= st_d == ERR;
    end
  end
  assign bus.cfg_in_ready = ready_q;
  assign bus.frame_data   = data_q;
  assign bus.frame_strobe = strobe_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.err          = err_q;
endmodule
